// File: rtl/chrono_pkg.sv
// Shared types and constants for the chrono_counter stopwatch/timer.
package chrono_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int unsigned SEC_MAX = 59;
  localparam int unsigned MIN_MAX = 59;

  // Bits needed to hold values 0..n-1 (never less than one bit).
  function automatic int unsigned field_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/chrono_prescaler.sv
// Free-running divider: counts 0..DIV-1 while enabled, holds its value
// while disabled, and flags the last count of each interval.
module chrono_prescaler #(
  parameter int unsigned DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned CW = (DIV <= 2) ? 1 : $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count;

  // Interval counter; paused intervals resume from the held value.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (en) begin
      if (count == LAST) count <= '0;
      else               count <= count + 1'b1;
    end
  end

  assign tick = en && (count == LAST);

endmodule

// File: rtl/chrono_counter.sv
// Stopwatch / countdown timer with cascaded sub/sec/min/hr fields.
// Optional lap capture is compiled in with the CHRONO_LAP_EN macro.
module chrono_counter
  import chrono_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 100_000_000,
  parameter int unsigned TICK_HZ     = 100,
  parameter int unsigned MAX_HOURS   = 23
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   start,
  input  logic                                   stop,
  input  logic                                   clear,
  input  logic                                   mode_down,
  input  logic                                   load_valid,
  output logic                                   load_ready,
  input  logic [field_width(TICK_HZ)-1:0]        load_sub,
  input  logic [5:0]                             load_sec,
  input  logic [5:0]                             load_min,
  input  logic [field_width(MAX_HOURS+1)-1:0]    load_hr,
  output logic [field_width(TICK_HZ)-1:0]        sub,
  output logic [5:0]                             sec,
  output logic [5:0]                             min,
  output logic [field_width(MAX_HOURS+1)-1:0]    hr,
  output logic                                   running,
  output logic                                   tick,
  output logic                                   wrap,
  output logic                                   expired,
  output logic                                   load_err
`ifdef CHRONO_LAP_EN
  ,
  input  logic                                   lap,
  output logic [field_width(TICK_HZ)-1:0]        lap_sub,
  output logic [5:0]                             lap_sec,
  output logic [5:0]                             lap_min,
  output logic [field_width(MAX_HOURS+1)-1:0]    lap_hr,
  output logic                                   lap_valid
`endif
);

  localparam int unsigned DIV = CLK_FREQ_HZ / TICK_HZ;
  localparam int unsigned SW  = field_width(TICK_HZ);
  localparam int unsigned HW  = field_width(MAX_HOURS + 1);

  localparam logic [SW-1:0] SUB_LAST = SW'(TICK_HZ - 1);
  localparam logic [5:0]    SEC_LAST = 6'(SEC_MAX);
  localparam logic [5:0]    MIN_LAST = 6'(MIN_MAX);
  localparam logic [HW-1:0] HR_LAST  = HW'(MAX_HOURS);

  state_t        state, state_nxt;
  logic          dir_down;
  logic          presc_tick, presc_en, presc_clr;
  logic [SW-1:0] sub_nxt;
  logic [5:0]    sec_nxt, min_nxt;
  logic [HW-1:0] hr_nxt;
  logic          tick_nxt, wrap_nxt, expired_nxt, load_err_nxt;
  logic          load_acc, load_ok, all_zero;
  logic          sub_end, sec_end, min_end, hr_end;
  logic          sub_z, sec_z, min_z, hr_z;

  chrono_prescaler #(.DIV(DIV)) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clr   (presc_clr),
    .en    (presc_en),
    .tick  (presc_tick)
  );

  assign load_ready = (state != RUN);
  assign running    = (state == RUN);

  assign load_acc = load_valid && load_ready && !clear;
  assign load_ok  = (32'(load_sub) < TICK_HZ) && (32'(load_sec) <= SEC_MAX) &&
                    (32'(load_min) <= MIN_MAX) && (32'(load_hr) <= MAX_HOURS);

  assign sub_end = (sub == SUB_LAST);
  assign sec_end = (sec == SEC_LAST);
  assign min_end = (min == MIN_LAST);
  assign hr_end  = (hr == HR_LAST);
  assign sub_z   = (sub == '0);
  assign sec_z   = (sec == '0);
  assign min_z   = (min == '0);
  assign hr_z    = (hr == '0);
  assign all_zero = sub_z && sec_z && min_z && hr_z;

  // Direction is frozen while running; it follows mode_down otherwise.
  always_ff @(posedge clk) begin
    if (reset)              dir_down <= 1'b0;
    else if (state != RUN)  dir_down <= mode_down;
  end

  // State, field and pulse registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      sub      <= '0;
      sec      <= '0;
      min      <= '0;
      hr       <= '0;
      tick     <= 1'b0;
      wrap     <= 1'b0;
      expired  <= 1'b0;
      load_err <= 1'b0;
    end else begin
      state    <= state_nxt;
      sub      <= sub_nxt;
      sec      <= sec_nxt;
      min      <= min_nxt;
      hr       <= hr_nxt;
      tick     <= tick_nxt;
      wrap     <= wrap_nxt;
      expired  <= expired_nxt;
      load_err <= load_err_nxt;
    end
  end

  // Control priority clear > load > stop > start, then field stepping on tick.
  always_comb begin
    state_nxt    = state;
    sub_nxt      = sub;
    sec_nxt      = sec;
    min_nxt      = min;
    hr_nxt       = hr;
    tick_nxt     = 1'b0;
    wrap_nxt     = 1'b0;
    expired_nxt  = 1'b0;
    load_err_nxt = 1'b0;
    presc_clr    = clear;
    // stop on the final prescaler count suppresses that tick and holds DIV-1
    presc_en     = (state == RUN) && !stop && !clear;

    if (clear) begin
      state_nxt = IDLE;
      sub_nxt   = '0;
      sec_nxt   = '0;
      min_nxt   = '0;
      hr_nxt    = '0;
    end else if (load_acc) begin
      if (load_ok) begin
        state_nxt = IDLE;
        presc_clr = 1'b1;
        sub_nxt   = load_sub;
        sec_nxt   = load_sec;
        min_nxt   = load_min;
        hr_nxt    = load_hr;
      end else begin
        load_err_nxt = 1'b1;
      end
    end else if (state == RUN) begin
      if (stop) begin
        state_nxt = PAUSE;
      end else if (presc_tick) begin
        tick_nxt = 1'b1;
        if (dir_down) begin
          sub_nxt = sub_z ? SUB_LAST : sub - 1'b1;
          if (sub_z) sec_nxt = sec_z ? SEC_LAST : sec - 1'b1;
          if (sub_z && sec_z) min_nxt = min_z ? MIN_LAST : min - 1'b1;
          if (sub_z && sec_z && min_z) hr_nxt = hr_z ? HR_LAST : hr - 1'b1;
          if ((sub == SW'(1)) && sec_z && min_z && hr_z) begin
            state_nxt   = DONE;
            expired_nxt = 1'b1;
          end
        end else begin
          sub_nxt = sub_end ? '0 : sub + 1'b1;
          if (sub_end) sec_nxt = sec_end ? '0 : sec + 1'b1;
          if (sub_end && sec_end) min_nxt = min_end ? '0 : min + 1'b1;
          if (sub_end && sec_end && min_end) hr_nxt = hr_end ? '0 : hr + 1'b1;
          wrap_nxt = sub_end && sec_end && min_end && hr_end;
        end
      end
    end else if (start && (state == IDLE || state == PAUSE) &&
                 !(mode_down && all_zero)) begin
      state_nxt = RUN;
    end
  end

`ifdef CHRONO_LAP_EN
  // Lap capture takes the field values of the request cycle, before any update.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      lap_sub   <= '0;
      lap_sec   <= '0;
      lap_min   <= '0;
      lap_hr    <= '0;
      lap_valid <= 1'b0;
    end else begin
      lap_valid <= lap && (state == RUN);
      if (lap && (state == RUN)) begin
        lap_sub <= sub;
        lap_sec <= sec;
        lap_min <= min;
        lap_hr  <= hr;
      end
    end
  end
`endif

endmodule

// File: tb/tb_chrono_counter.sv
// Directed self-checking bench for chrono_counter (DIV = 100 cycles per tick).
module tb_chrono_counter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0, stop = 1'b0, clear = 1'b0, mode_down = 1'b0;
  logic       load_valid = 1'b0;
  logic       load_ready;
  logic [3:0] load_sub = '0;
  logic [5:0] load_sec = '0, load_min = '0;
  logic [4:0] load_hr = '0;
  logic [3:0] sub;
  logic [5:0] sec, min;
  logic [4:0] hr;
  logic       running, tick, wrap, expired, load_err;
`ifdef CHRONO_LAP_EN
  logic       lap = 1'b0;
  logic [3:0] lap_sub;
  logic [5:0] lap_sec, lap_min;
  logic [4:0] lap_hr;
  logic       lap_valid;
`endif

  int checks = 0;
  int errors = 0;
  int n;

  chrono_counter #(.CLK_FREQ_HZ(1000), .TICK_HZ(10), .MAX_HOURS(23)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear),
    .mode_down(mode_down), .load_valid(load_valid), .load_ready(load_ready),
    .load_sub(load_sub), .load_sec(load_sec), .load_min(load_min), .load_hr(load_hr),
    .sub(sub), .sec(sec), .min(min), .hr(hr), .running(running), .tick(tick),
    .wrap(wrap), .expired(expired), .load_err(load_err)
`ifdef CHRONO_LAP_EN
    , .lap(lap), .lap_sub(lap_sub), .lap_sec(lap_sec), .lap_min(lap_min),
    .lap_hr(lap_hr), .lap_valid(lap_valid)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_time(input string tag, input int s, input int sc, input int m, input int h);
    chk({tag, ".sub"}, 32'(sub), s);
    chk({tag, ".sec"}, 32'(sec), sc);
    chk({tag, ".min"}, 32'(min), m);
    chk({tag, ".hr"},  32'(hr),  h);
  endtask

  // Steps until tick is seen, bounded; returns the number of edges taken.
  task automatic wait_tick(output int cnt);
    cnt = 0;
    do begin
      step();
      cnt++;
    end while (!tick && cnt < 300);
  endtask

  task automatic do_load(input int s, input int sc, input int m, input int h);
    load_sub = 4'(s); load_sec = 6'(sc); load_min = 6'(m); load_hr = 5'(h);
    load_valid = 1'b1;
    step();
    load_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; step(); stop = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1; step(); clear = 1'b0;
  endtask

  initial begin
    // Reset state
    step(); step();
    reset = 1'b0;
    chk_time("reset", 0, 0, 0, 0);
    chk("reset.running", 32'(running), 0);
    chk("reset.tick", 32'(tick), 0);
    chk("reset.wrap", 32'(wrap), 0);
    chk("reset.expired", 32'(expired), 0);
    chk("reset.load_err", 32'(load_err), 0);
    chk("reset.load_ready", 32'(load_ready), 1);

    // First tick 100 cycles after the start edge
    pulse_start();
    chk("start.running", 32'(running), 1);
    chk("start.load_ready", 32'(load_ready), 0);
    wait_tick(n);
    chk("first_tick.latency", n, 100);
    chk("first_tick.sub", 32'(sub), 1);

    // Carry 0:59:59:9 -> 1:00:00:0
    pulse_clear();
    chk_time("clear", 0, 0, 0, 0);
    chk("clear.running", 32'(running), 0);
    do_load(9, 59, 59, 0);
    chk_time("load1", 9, 59, 59, 0);
    chk("load1.load_err", 32'(load_err), 0);
    pulse_start();
    wait_tick(n);
    chk("carry.latency", n, 100);
    chk_time("carry", 0, 0, 0, 1);
    chk("carry.wrap", 32'(wrap), 0);

    // Wrap 23:59:59:9 -> 0 loaded while paused
    pulse_stop();
    chk("stop.running", 32'(running), 0);
    do_load(9, 59, 59, 23);
    chk_time("load2", 9, 59, 59, 23);
    pulse_start();
    wait_tick(n);
    chk("wrap.latency", n, 100);
    chk_time("wrap", 0, 0, 0, 0);
    chk("wrap.pulse", 32'(wrap), 1);
    step();
    chk("wrap.once", 32'(wrap), 0);

    // Countdown 0:00:00:2 -> DONE
    pulse_clear();
    mode_down = 1'b1;
    pulse_start();
    chk("down_zero_start.running", 32'(running), 0);
    do_load(2, 0, 0, 0);
    pulse_start();
    chk("down.running", 32'(running), 1);
    wait_tick(n);
    chk("down1.latency", n, 100);
    chk("down1.sub", 32'(sub), 1);
    chk("down1.expired", 32'(expired), 0);
    wait_tick(n);
    chk("down2.latency", n, 100);
    chk_time("down2", 0, 0, 0, 0);
    chk("down2.expired", 32'(expired), 1);
    chk("down2.running", 32'(running), 0);
    chk("down2.load_ready", 32'(load_ready), 1);
    step();
    chk("down2.expired_once", 32'(expired), 0);
    do_load(5, 0, 0, 0);
    do_load(0, 0, 0, 0);
    pulse_start();
    chk("done_start_ignored.running", 32'(running), 0);

    // Pause/resume: 50 counts, stop, 500 idle cycles, tick 50 after resume
    pulse_clear();
    mode_down = 1'b0;
    pulse_start();
    for (int i = 0; i < 50; i++) step();
    pulse_stop();
    chk("pause.running", 32'(running), 0);
    for (int i = 0; i < 500; i++) step();
    chk("pause.sub_held", 32'(sub), 0);
    pulse_start();
    wait_tick(n);
    chk("resume.latency", n, 50);
    chk("resume.sub", 32'(sub), 1);

    // Out-of-range preset rejected
    pulse_stop();
    do_load(0, 60, 0, 0);
    chk("bad_load.load_err", 32'(load_err), 1);
    chk_time("bad_load", 1, 0, 0, 0);
    step();
    chk("bad_load.err_once", 32'(load_err), 0);

    // Preset during RUN not accepted
    pulse_start();
    chk("run_load.load_ready", 32'(load_ready), 0);
    do_load(5, 0, 0, 0);
    chk("run_load.sub", 32'(sub), 1);
    chk("run_load.load_err", 32'(load_err), 0);
    chk("run_load.running", 32'(running), 1);

    // Stop and start together in RUN: stop wins
    start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
    chk("start_stop.running", 32'(running), 0);

`ifdef CHRONO_LAP_EN
    pulse_clear();
    chk("lap_clear.lap_sub", 32'(lap_sub), 0);
    pulse_start();
    for (int t = 0; t < 7; t++) wait_tick(n);
    chk("lap.pre_sub", 32'(sub), 7);
    lap = 1'b1; step(); lap = 1'b0;
    chk("lap.valid", 32'(lap_valid), 1);
    chk("lap.sub", 32'(lap_sub), 7);
    chk("lap.running", 32'(running), 1);
    step();
    chk("lap.valid_once", 32'(lap_valid), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/chrono_counter.md
# chrono_counter

Parametrised stopwatch/countdown timer: a clock prescaler generates a sub-second tick that drives cascaded sub-second, seconds, minutes and hours fields. Start/stop/clear controls, loadable preset and an up/down mode are included. It is the generalised successor of the fixed 100 MHz, centisecond/second/minute clock mechanism. Outputs feed display and alarm logic in the same clock domain.

## Interface
- CLK_FREQ_HZ, 100_000_000, input clock frequency
- TICK_HZ, 100, sub-second resolution; must divide CLK_FREQ_HZ exactly; DIV = CLK_FREQ_HZ/TICK_HZ ≥ 2
- MAX_HOURS, 23, hours field wraps/saturates at this value
- clk  in  1  clock; one clock domain
- reset  in  1  synchronous, active-high reset
- start  in  1  pulse; begin/resume counting
- stop  in  1  pulse; pause counting
- clear  in  1  pulse; zero all fields and prescaler, go IDLE
- mode_down  in  1  0 = count up, 1 = count down; sampled only in IDLE/PAUSE
- load_valid  in  1  preset request
- load_ready  out  1  high when state ≠ RUN
- load_sub/load_sec/load_min/load_hr  in  SW/6/6/HW  preset values; SW = $clog2(TICK_HZ), HW = $clog2(MAX_HOURS+1)
- sub/sec/min/hr  out  SW/6/6/HW  current time
- running  out  1  state == RUN
- tick  out  1  one-cycle pulse on every sub-second increment/decrement
- wrap  out  1  one-cycle pulse when up-count rolls MAX_HOURS:59:59:(TICK_HZ-1) → 0
- expired  out  1  one-cycle pulse when down-count reaches zero
- load_err  out  1  one-cycle pulse when an accepted preset is out of range

## Operation
- States IDLE, RUN, PAUSE, DONE. Reset → IDLE; all outputs 0 except load_ready = 1.
- Priority per cycle: reset > clear > load > stop > start.
- IDLE/PAUSE + start → RUN; start in down mode with all fields zero is ignored.
- RUN + stop → PAUSE. start and stop in same cycle: stop wins.
- DONE + start → ignored; DONE left only by clear, load or reset.
- clear from any state → IDLE, fields and prescaler 0.
- Load handshake: accepted when load_valid && load_ready. Range check sub < TICK_HZ, sec < 60, min < 60, hr ≤ MAX_HOURS; pass → fields take preset, prescaler 0, state IDLE; fail → fields unchanged, load_err pulses, state unchanged.
- Up mode: sub increments; carry into sec at TICK_HZ-1, sec→min at 59, min→hr at 59, hr wraps at MAX_HOURS with wrap pulse; counting continues.
- Down mode: borrow chain mirror of up; when tick makes all fields zero → DONE, expired pulses, running drops same cycle fields show zero.
- mode_down changes during RUN are ignored until next IDLE/PAUSE.

## Timing
- Prescaler counts 0..DIV-1 only in RUN; tick asserts on the cycle prescaler == DIV-1, fields update on that edge (tick and new field values visible together the cycle after).
- First tick after start from IDLE occurs DIV cycles after the start edge.
- PAUSE holds prescaler value; resume completes the remaining partial interval (no time lost or gained).
- stop on the same cycle as prescaler == DIV-1: stop wins, no tick, prescaler holds DIV-1.
- Load/clear: effective next edge; load_ready drops the cycle after entering RUN.
- Reset mid-count: next edge all zero, IDLE.

## Configuration
- CHRONO_LAP_EN defined: adds input lap (pulse) and outputs lap_sub/lap_sec/lap_min/lap_hr plus lap_valid. lap in RUN copies the field values of that cycle (pre-update) into lap registers, lap_valid pulses one cycle later; lap outside RUN ignored; lap registers cleared by reset/clear.
- Not defined: no lap ports or registers exist.

## Structure
- Package chrono_pkg: state enum (IDLE, RUN, PAUSE, DONE), constants SEC_MAX = 59, MIN_MAX = 59, width helper functions.
- Sub-module chrono_prescaler: parameter DIV, inputs clk, reset, clr, en; output tick; holds count when en low.

## Test plan
- CLK_FREQ_HZ=1000, TICK_HZ=10, reset then start → first tick exactly 100 cycles later, sub = 1.
- Load 0:59:59:9 up, start → after one tick fields 1:00:00:0; load 23:59:59:9 → next tick wraps to 0, wrap pulses once.
- Down mode load 0:00:00:2, start → two ticks later fields zero, expired one cycle, state DONE, further start ignored.
- Start, stop after 50 cycles, wait 500, start → tick exactly 50 cycles after resume.
- Load sec = 60 → load_err pulses, fields unchanged; load during RUN → load_ready 0, not accepted.
- CHRONO_LAP_EN: lap at sub = 7 during RUN → lap_sub = 7 and lap_valid next cycle while counting continues.
